// File: rtl/fusion_pkg.sv
// Shared types and constants for the FUSION blend-pipeline control slice.
package fusion_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fusion_state_e;

   localparam int unsigned FUSION_PIPE_LAT = 2;
   localparam int unsigned STATS_W         = 32;
   localparam int unsigned FRAME_IDX_W     = 16;

   // Beats in one square frame of dim x dim pixels at ppb pixels per beat.
   function automatic int unsigned frame_beats(input int unsigned dim, input int unsigned ppb);
      return (dim * dim) / ppb;
   endfunction

endpackage

// File: rtl/fusion_vpipe.sv
// Valid/last shadow of the FUSION register stages; freezes as a whole under stall.
module fusion_vpipe
   import fusion_pkg::*;
#(
   parameter int unsigned DEPTH = FUSION_PIPE_LAT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic stall,
   input  logic in_v,
   input  logic in_last,
   output logic out_v,
   output logic out_last
);

   logic [DEPTH-1:0] v_q, v_d;
   logic [DEPTH-1:0] l_q, l_d;

   // Bubbles travel with the data so FUSION and this shadow stay aligned.
   always_comb begin
      v_d = v_q;
      l_d = l_q;
      if (!stall) begin
         v_d = {v_q[DEPTH-2:0], in_v};
         l_d = {l_q[DEPTH-2:0], in_last};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         l_q <= '0;
      end else begin
         v_q <= v_d;
         l_q <= l_d;
      end
   end

   assign out_v    = v_q[DEPTH-1];
   assign out_last = l_q[DEPTH-1];

endmodule

// File: rtl/fusion_ctrl.sv
// Frame sequencer and handshake controller for one FUSION datapath.
// Optional stall/starve statistics ports are built when FUSION_CTRL_PERF_EN is defined.
module fusion_ctrl
   import fusion_pkg::*;
#(
   parameter int unsigned PIXELS_PER_BEAT = 16,
   parameter int unsigned IMAGE_DIM       = 512,
   parameter int unsigned FRAME_BEATS     = frame_beats(IMAGE_DIM, PIXELS_PER_BEAT),
   parameter int unsigned PIPE_LAT        = FUSION_PIPE_LAT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic [FRAME_IDX_W-1:0] frame_idx,
   input  logic                   old_valid,
   input  logic                   new_valid,
   input  logic                   del_valid,
   output logic                   in_ready,
   output logic                   fus_stall,
   output logic                   out_valid,
   output logic                   out_last,
   input  logic                   out_ready
`ifdef FUSION_CTRL_PERF_EN
   ,
   output logic [STATS_W-1:0]     stall_cycles,
   output logic [STATS_W-1:0]     starve_cycles
`endif
);

   localparam int unsigned       CNT_W     = $clog2(FRAME_BEATS + 1);
   localparam logic [CNT_W-1:0]  BEATS     = CNT_W'(FRAME_BEATS);
   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(FRAME_BEATS - 1);

   fusion_state_e          state_q, state_d;
   logic [CNT_W-1:0]       in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0]       out_cnt_q, out_cnt_d;
   logic [FRAME_IDX_W-1:0] frame_idx_q, frame_idx_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic v2, l2;
   logic all_valid, stall_c, in_ready_c;
   logic fire_in, fire_out, frame_go, last_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)               state_d = RUN;
         RUN:     if (in_cnt_q == BEATS)   state_d = DRAIN;
         DRAIN:   if (out_cnt_q == BEATS)  state_d = IDLE;
         default:                          state_d = IDLE;
      endcase
   end

   // Handshakes, counters and registered status derived from the current state.
   always_comb begin
      all_valid   = old_valid & new_valid & del_valid;
      stall_c     = v2 & ~out_ready;
      in_ready_c  = (state_q == RUN) & ~stall_c & (in_cnt_q < BEATS);
      fire_in     = in_ready_c & all_valid;
      fire_out    = v2 & out_ready;
      frame_go    = (state_q == IDLE) & start;
      last_in     = fire_in & (in_cnt_q == LAST_BEAT);

      in_cnt_d    = in_cnt_q;
      out_cnt_d   = out_cnt_q;
      if (frame_go) begin
         in_cnt_d  = '0;
         out_cnt_d = '0;
      end else begin
         if (fire_in)  in_cnt_d  = in_cnt_q + CNT_W'(1);
         if (fire_out) out_cnt_d = out_cnt_q + CNT_W'(1);
      end

      busy_d      = (state_d != IDLE);
      done_d      = fire_out & (out_cnt_q == LAST_BEAT);
      frame_idx_d = frame_idx_q + FRAME_IDX_W'(done_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         frame_idx_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         frame_idx_q <= frame_idx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   fusion_vpipe #(
      .DEPTH (PIPE_LAT)
   ) u_vpipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .stall    (stall_c),
      .in_v     (fire_in),
      .in_last  (last_in),
      .out_v    (v2),
      .out_last (l2)
   );

   assign busy      = busy_q;
   assign done      = done_q;
   assign frame_idx = frame_idx_q;
   assign in_ready  = in_ready_c;
   assign fus_stall = stall_c;
   assign out_valid = v2;
   assign out_last  = l2;

`ifdef FUSION_CTRL_PERF_EN
   logic [STATS_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [STATS_W-1:0] starve_cnt_q, starve_cnt_d;
   logic               stall_inc, starve_inc;

   // Saturating statistics, restarted by an accepted start.
   always_comb begin
      stall_inc    = stall_c & (state_q != IDLE);
      starve_inc   = (state_q == RUN) & (in_cnt_q < BEATS) & ~all_valid;
      stall_cnt_d  = stall_cnt_q;
      starve_cnt_d = starve_cnt_q;
      if (frame_go) begin
         stall_cnt_d  = '0;
         starve_cnt_d = '0;
      end else begin
         if (stall_inc && (stall_cnt_q != '1))   stall_cnt_d  = stall_cnt_q + STATS_W'(1);
         if (starve_inc && (starve_cnt_q != '1)) starve_cnt_d = starve_cnt_q + STATS_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q  <= '0;
         starve_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign stall_cycles  = stall_cnt_q;
   assign starve_cycles = starve_cnt_q;
`endif

endmodule
